// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port CPU_MEM SRAM: round-robin or fixed
// priority grant, one-cycle SRAM command, read data returned to the issuing port.
//
// state | meaning
// IDLE  | no access in flight; grant issued combinationally to the winner
// CMD   | command driven on csb0/web0/addr0/din0 for exactly one cycle
// RDATA | SRAM output settling; captured into the owner's rdata on exit
module mem_port_arbiter #(
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter bit FAIR = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_a_req,
  input  logic          i_a_we,
  input  logic [AW-1:0] i_a_addr,
  input  logic [DW-1:0] i_a_wdata,
  output logic          o_a_gnt,
  output logic          o_a_rvalid,
  output logic [DW-1:0] o_a_rdata,
  input  logic          i_b_req,
  input  logic          i_b_we,
  input  logic [AW-1:0] i_b_addr,
  input  logic [DW-1:0] i_b_wdata,
  output logic          o_b_gnt,
  output logic          o_b_rvalid,
  output logic [DW-1:0] o_b_rdata,
  output logic          o_csb0,
  output logic          o_web0,
  output logic [AW-1:0] o_addr0,
  output logic [DW-1:0] o_din0,
  input  logic [DW-1:0] i_dout0,
  output logic          o_busy
);

  typedef enum logic [1:0] {IDLE, CMD, RDATA} state_t;

  state_t        state_q, state_d;
  logic          csb_q, csb_d;
  logic          web_q, web_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          owner_b_q, owner_b_d;
  logic          last_b_q, last_b_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic          a_win, b_win;

  // A wins a tie unless round-robin says B is due (last grant went to A).
  always_comb begin
    a_win = 1'b0;
    b_win = 1'b0;
    if (state_q == IDLE) begin
      if (i_a_req && (!i_b_req || !FAIR || last_b_q)) a_win = 1'b1;
      else if (i_b_req)                                b_win = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    csb_d      = csb_q;
    web_d      = web_q;
    addr_d     = addr_q;
    din_d      = din_q;
    owner_b_d  = owner_b_q;
    last_b_d   = last_b_q;
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    case (state_q)
      IDLE: begin
        if (a_win || b_win) begin
          state_d   = CMD;
          csb_d     = 1'b0;
          owner_b_d = b_win;
          last_b_d  = b_win;
          web_d     = b_win ? ~i_b_we    : ~i_a_we;
          addr_d    = b_win ? i_b_addr   : i_a_addr;
          din_d     = b_win ? i_b_wdata  : i_a_wdata;
        end
      end
      CMD: begin
        csb_d   = 1'b1;
        web_d   = 1'b1;
        state_d = web_q ? RDATA : IDLE;
      end
      RDATA: begin
        state_d = IDLE;
        if (owner_b_q) begin
          b_rdata_d  = i_dout0;
          b_rvalid_d = 1'b1;
        end else begin
          a_rdata_d  = i_dout0;
          a_rvalid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      csb_q      <= 1'b1;
      web_q      <= 1'b1;
      addr_q     <= '0;
      din_q      <= '0;
      owner_b_q  <= 1'b0;
      last_b_q   <= 1'b1;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      csb_q      <= csb_d;
      web_q      <= web_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      owner_b_q  <= owner_b_d;
      last_b_q   <= last_b_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Grant is combinational; masking with reset keeps it low while reset is held.
  assign o_a_gnt    = a_win & ~i_reset;
  assign o_b_gnt    = b_win & ~i_reset;
  assign o_a_rvalid = a_rvalid_q;
  assign o_b_rvalid = b_rvalid_q;
  assign o_a_rdata  = a_rdata_q;
  assign o_b_rdata  = b_rdata_q;
  assign o_csb0     = csb_q;
  assign o_web0     = web_q;
  assign o_addr0    = addr_q;
  assign o_din0     = din_q;
  assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (round-robin and fixed priority), each
// with its own SRAM model, checked every cycle against a transaction-schedule model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_req[2], a_we[2], b_req[2], b_we[2];
  logic [7:0] a_addr[2], a_wdata[2], b_addr[2], b_wdata[2];
  logic       a_gnt[2], a_rvalid[2], b_gnt[2], b_rvalid[2];
  logic [7:0] a_rdata[2], b_rdata[2];
  logic       csb[2], web[2], busy[2];
  logic [7:0] addr0[2], din0[2], dout0[2];

  mem_port_arbiter #(.AW(8), .DW(8), .FAIR(1'b1)) u_fair (
    .i_clk(clk), .i_reset(rst),
    .i_a_req(a_req[0]), .i_a_we(a_we[0]), .i_a_addr(a_addr[0]), .i_a_wdata(a_wdata[0]),
    .o_a_gnt(a_gnt[0]), .o_a_rvalid(a_rvalid[0]), .o_a_rdata(a_rdata[0]),
    .i_b_req(b_req[0]), .i_b_we(b_we[0]), .i_b_addr(b_addr[0]), .i_b_wdata(b_wdata[0]),
    .o_b_gnt(b_gnt[0]), .o_b_rvalid(b_rvalid[0]), .o_b_rdata(b_rdata[0]),
    .o_csb0(csb[0]), .o_web0(web[0]), .o_addr0(addr0[0]), .o_din0(din0[0]),
    .i_dout0(dout0[0]), .o_busy(busy[0]));

  mem_port_arbiter #(.AW(8), .DW(8), .FAIR(1'b0)) u_prio (
    .i_clk(clk), .i_reset(rst),
    .i_a_req(a_req[1]), .i_a_we(a_we[1]), .i_a_addr(a_addr[1]), .i_a_wdata(a_wdata[1]),
    .o_a_gnt(a_gnt[1]), .o_a_rvalid(a_rvalid[1]), .o_a_rdata(a_rdata[1]),
    .i_b_req(b_req[1]), .i_b_we(b_we[1]), .i_b_addr(b_addr[1]), .i_b_wdata(b_wdata[1]),
    .o_b_gnt(b_gnt[1]), .o_b_rvalid(b_rvalid[1]), .o_b_rdata(b_rdata[1]),
    .o_csb0(csb[1]), .o_web0(web[1]), .o_addr0(addr0[1]), .o_din0(din0[1]),
    .i_dout0(dout0[1]), .o_busy(busy[1]));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM models: synchronous write, registered read output.
  logic [7:0] sram[2][256];
  bit sram_init = 1'b0;
  always @(posedge clk) begin
    if (!sram_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 256; i++) sram[k][i] = 8'(i) ^ 8'hA5;
      sram_init = 1'b1;
    end
    for (int k = 0; k < 2; k++)
      if (csb[k] === 1'b0) begin
        if (web[k] === 1'b0) sram[k][addr0[k]] = din0[k];
        else                 dout0[k] <= sram[k][addr0[k]];
      end
  end

  // Reference: each grant schedules a command one cycle later, a read result
  // three cycles later, and keeps the port busy for 2 (write) or 3 (read) cycles.
  logic [7:0] mm[2][256];
  bit         mm_init = 1'b0;
  int         free_at[2], cmd_cyc[2], rv_cyc[2];
  bit         rv_b[2], last_b[2], cmd_web[2];
  logic [7:0] rv_data[2], cur_addr[2], cur_din[2], exp_rda[2], exp_rdb[2];
  bit         idle, in_cmd, rva, rvb, ga, gb;

  always @(negedge clk) begin
    if (!mm_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 256; i++) mm[k][i] = 8'(i) ^ 8'hA5;
      mm_init = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        free_at[k] = 0; cmd_cyc[k] = -1; rv_cyc[k] = -1; last_b[k] = 1'b1;
        cur_addr[k] = 8'h00; cur_din[k] = 8'h00; exp_rda[k] = 8'h00; exp_rdb[k] = 8'h00;
        check($sformatf("rst_gnt_a[%0d]", k), a_gnt[k], 0);
        check($sformatf("rst_gnt_b[%0d]", k), b_gnt[k], 0);
        check($sformatf("rst_csb[%0d]", k), csb[k], 1);
        check($sformatf("rst_web[%0d]", k), web[k], 1);
        check($sformatf("rst_addr[%0d]", k), addr0[k], 0);
        check($sformatf("rst_din[%0d]", k), din0[k], 0);
        check($sformatf("rst_busy[%0d]", k), busy[k], 0);
        check($sformatf("rst_rv[%0d]", k), {a_rvalid[k], b_rvalid[k]}, 0);
        check($sformatf("rst_rd[%0d]", k), {a_rdata[k], b_rdata[k]}, 0);
      end else begin
        idle   = (cyc >= free_at[k]);
        in_cmd = (cyc == cmd_cyc[k]);
        rva    = (cyc == rv_cyc[k]) && !rv_b[k];
        rvb    = (cyc == rv_cyc[k]) &&  rv_b[k];
        if (rva) exp_rda[k] = rv_data[k];
        if (rvb) exp_rdb[k] = rv_data[k];
        ga = 1'b0;
        gb = 1'b0;
        if (idle) begin
          if (a_req[k] && (!b_req[k] || k == 1 || last_b[k])) ga = 1'b1;
          else if (b_req[k]) gb = 1'b1;
        end
        check($sformatf("gnt_a[%0d]", k), a_gnt[k], ga);
        check($sformatf("gnt_b[%0d]", k), b_gnt[k], gb);
        check($sformatf("busy[%0d]", k), busy[k], !idle);
        check($sformatf("csb[%0d]", k), csb[k], !in_cmd);
        check($sformatf("web[%0d]", k), web[k], in_cmd ? cmd_web[k] : 1'b1);
        check($sformatf("addr0[%0d]", k), addr0[k], cur_addr[k]);
        check($sformatf("din0[%0d]", k), din0[k], cur_din[k]);
        check($sformatf("rvalid_a[%0d]", k), a_rvalid[k], rva);
        check($sformatf("rvalid_b[%0d]", k), b_rvalid[k], rvb);
        check($sformatf("rdata_a[%0d]", k), a_rdata[k], exp_rda[k]);
        check($sformatf("rdata_b[%0d]", k), b_rdata[k], exp_rdb[k]);
        if (ga || gb) begin
          cmd_cyc[k]  = cyc + 1;
          cur_addr[k] = gb ? b_addr[k] : a_addr[k];
          cur_din[k]  = gb ? b_wdata[k] : a_wdata[k];
          cmd_web[k]  = gb ? !b_we[k] : !a_we[k];
          last_b[k]   = gb;
          if (!cmd_web[k]) begin
            mm[k][cur_addr[k]] = cur_din[k];
            free_at[k] = cyc + 2;
          end else begin
            rv_cyc[k]  = cyc + 3;
            rv_b[k]    = gb;
            rv_data[k] = mm[k][cur_addr[k]];
            free_at[k] = cyc + 3;
          end
        end
      end
    end
  end

  // Observed grant order per instance (0 = A, 1 = B).
  int gq0[$], gq1[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (a_gnt[0] === 1'b1) gq0.push_back(0);
      if (b_gnt[0] === 1'b1) gq0.push_back(1);
      if (a_gnt[1] === 1'b1) gq1.push_back(0);
      if (b_gnt[1] === 1'b1) gq1.push_back(1);
    end
  end

  task automatic req_op(input int k, input bit pb, input bit we, input logic [7:0] ad,
                        input logic [7:0] wd, output int gcyc);
    if (pb) begin b_req[k] = 1'b1; b_we[k] = we; b_addr[k] = ad; b_wdata[k] = wd; end
    else    begin a_req[k] = 1'b1; a_we[k] = we; a_addr[k] = ad; a_wdata[k] = wd; end
    gcyc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if ((pb ? b_gnt[k] : a_gnt[k]) === 1'b1) begin
        gcyc = cyc;
        break;
      end
    end
    check("gnt_seen", gcyc >= 0, 1);
    @(posedge clk);
    #1;
    if (pb) b_req[k] = 1'b0;
    else    a_req[k] = 1'b0;
  endtask

  task automatic wait_rv(input int k, input bit pb, output int rc, output logic [7:0] rd);
    rc = -1;
    rd = 8'h00;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if ((pb ? b_rvalid[k] : a_rvalid[k]) === 1'b1) begin
        rc = cyc;
        rd = pb ? b_rdata[k] : a_rdata[k];
        break;
      end
    end
    check("rvalid_seen", rc >= 0, 1);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  int g0, g1, ga_c, gb_c, rca, rcb, gt;
  logic [7:0] rda, rdb;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      a_req[k] = 1'b0; a_we[k] = 1'b0; a_addr[k] = 8'h00; a_wdata[k] = 8'h00;
      b_req[k] = 1'b0; b_we[k] = 1'b0; b_addr[k] = 8'h00; b_wdata[k] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Round-robin, both held: A,B,A,B.
    g0 = gq0.size();
    fork
      begin int t; req_op(0, 0, 0, 8'h20, 8'h00, t); req_op(0, 0, 0, 8'h21, 8'h00, t); end
      begin int t; req_op(0, 1, 0, 8'h30, 8'h00, t); req_op(0, 1, 0, 8'h31, 8'h00, t); end
    join
    settle();
    check("rr_count", gq0.size() - g0, 4);
    if (gq0.size() >= g0 + 4) begin
      check("rr_order0", gq0[g0],     0);
      check("rr_order1", gq0[g0 + 1], 1);
      check("rr_order2", gq0[g0 + 2], 0);
      check("rr_order3", gq0[g0 + 3], 1);
    end
    check("rr_b_last_data", b_rdata[0], 8'h31 ^ 8'hA5);

    // Write then read back on A.
    req_op(0, 0, 1, 8'h10, 8'h5A, gt);
    req_op(0, 0, 0, 8'h10, 8'h00, gt);
    wait_rv(0, 0, rca, rda);
    check("wr_rd_latency", rca - gt, 3);
    check("wr_rd_data", rda, 8'h5A);
    settle();

    // B requests while A's read is in CMD.
    fork
      begin req_op(0, 0, 0, 8'h40, 8'h00, ga_c); wait_rv(0, 0, rca, rda); end
      begin
        for (int n = 0; n < 40; n++) begin
          @(negedge clk);
          if (a_gnt[0] === 1'b1) break;
        end
        @(posedge clk);
        #1;
        req_op(0, 1, 0, 8'h41, 8'h00, gb_c);
        wait_rv(0, 1, rcb, rdb);
      end
    join
    check("wait_gnt_gap", gb_c - ga_c, 3);
    check("wait_rv_gap", rcb - rca, 3);
    check("wait_a_data", rda, 8'h40 ^ 8'hA5);
    check("wait_b_data", rdb, 8'h41 ^ 8'hA5);
    settle();

    // Fixed priority: A,A,B even when round-robin would favour B.
    g1 = gq1.size();
    fork
      begin int t; req_op(1, 0, 0, 8'h50, 8'h00, t); req_op(1, 0, 0, 8'h51, 8'h00, t); end
      begin int t; req_op(1, 1, 0, 8'h60, 8'h00, t); end
    join
    settle();
    check("prio_count", gq1.size() - g1, 3);
    if (gq1.size() >= g1 + 3) begin
      check("prio_order0", gq1[g1],     0);
      check("prio_order1", gq1[g1 + 1], 0);
      check("prio_order2", gq1[g1 + 2], 1);
    end

    // Reset during RDATA.
    req_op(0, 0, 0, 8'h70, 8'h00, gt);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_csb", csb[0], 1);
    check("midrst_busy", busy[0], 0);
    check("midrst_rvalid", a_rvalid[0], 0);
    @(negedge clk);
    #1 rst = 1'b0;
    settle();
    g0 = gq0.size();
    fork
      req_op(0, 0, 0, 8'h01, 8'h00, ga_c);
      req_op(0, 1, 0, 8'h02, 8'h00, gb_c);
    join
    check("tie_after_reset", ga_c < gb_c, 1);
    if (gq0.size() > g0) check("tie_first_a", gq0[g0], 0);
    settle();

    // Address extremes.
    req_op(0, 0, 1, 8'hFF, 8'h3C, gt);
    req_op(0, 0, 0, 8'h00, 8'h00, gt);
    wait_rv(0, 0, rca, rda);
    check("addr00_data", rda, 8'hA5);
    req_op(0, 1, 0, 8'hFF, 8'h00, gt);
    wait_rv(0, 1, rcb, rdb);
    check("addrff_data", rdb, 8'h3C);
    check("addrff_latency", rcb - gt, 3);
    settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
